// File: rtl/tlk2711_rx_buf_ctrl.sv
// Receive-side ring-buffer scheduler for the TLK2711 link: hands out DDR slot
// addresses, tracks slot fill against host releases, drains and resets on loss.
module tlk2711_rx_buf_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_BUF    = 4,
   parameter int IDX_W      = 2,
   parameter int FLUSH_TO   = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_enable,
   input  logic [ADDR_WIDTH-1:0] i_cfg_base_addr,
   input  logic [ADDR_WIDTH-1:0] i_cfg_buf_stride,
   input  logic [15:0]           i_cfg_frames_per_buf,
   input  logic                  i_buf_release,
   input  logic                  i_rx_interrupt,
   input  logic                  i_loss_interrupt,
   input  logic                  i_fifo_empty,
   output logic                  o_rx_start,
   output logic [ADDR_WIDTH-1:0] o_rx_base_addr,
   output logic                  o_rx_fifo_rd,
   output logic                  o_soft_rst,
   output logic                  o_buf_done,
   output logic [IDX_W-1:0]      o_buf_done_idx,
   output logic [IDX_W-1:0]      o_wr_idx,
   output logic [IDX_W:0]        o_fill_level,
   output logic                  o_overflow,
   output logic [2:0]            o_state
);

   localparam int FC_W = (FLUSH_TO > 1) ? $clog2(FLUSH_TO) : 1;
   localparam logic [IDX_W:0]  FILL_FULL = (IDX_W+1)'(NUM_BUF);
   localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_TO - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_START    = 3'd1,
      S_RUN      = 3'd2,
      S_WAIT_BUF = 3'd3,
      S_FLUSH    = 3'd4,
      S_SRST     = 3'd5
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [ADDR_WIDTH-1:0]   stride_q, stride_d;
   logic [15:0]             fpb_q, fpb_d;
   logic [15:0]             frame_cnt_q, frame_cnt_d;
   logic [IDX_W-1:0]        wr_idx_q, wr_idx_d;
   logic [IDX_W:0]          fill_q, fill_d;
   logic [FC_W-1:0]         flush_cnt_q, flush_cnt_d;
   logic [1:0]              srst_cnt_q, srst_cnt_d;
   logic                    rx_start_q, rx_start_d;
   logic [ADDR_WIDTH-1:0]   rx_addr_q, rx_addr_d;
   logic                    buf_done_q, buf_done_d;
   logic [IDX_W-1:0]        done_idx_q, done_idx_d;
   logic                    soft_rst_q, soft_rst_d;
   logic                    overflow_q, overflow_d;
   logic                    complete;
   logic                    release_ok;

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      stride_d    = stride_q;
      fpb_d       = fpb_q;
      frame_cnt_d = frame_cnt_q;
      wr_idx_d    = wr_idx_q;
      flush_cnt_d = flush_cnt_q;
      srst_cnt_d  = srst_cnt_q;
      rx_start_d  = 1'b0;
      rx_addr_d   = rx_addr_q;
      buf_done_d  = 1'b0;
      done_idx_d  = done_idx_q;
      overflow_d  = overflow_q;

      // A completing frame is counted even when a loss arrives in the same cycle.
      complete   = (state_q == S_RUN) && i_rx_interrupt && (frame_cnt_q == fpb_q - 16'd1);
      release_ok = i_buf_release && (fill_q != '0);

      fill_d = fill_q;
      if (complete && !release_ok) begin
         fill_d = fill_q + (IDX_W+1)'(1);
      end else if (!complete && release_ok) begin
         fill_d = fill_q - (IDX_W+1)'(1);
      end

      if (complete) begin
         buf_done_d = 1'b1;
         done_idx_d = wr_idx_q;
         wr_idx_d   = wr_idx_q + IDX_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (i_enable && (i_cfg_frames_per_buf != 16'd0)) begin
               base_d   = i_cfg_base_addr;
               stride_d = i_cfg_buf_stride;
               fpb_d    = i_cfg_frames_per_buf;
               state_d  = S_START;
            end
         end
         S_START: begin
            frame_cnt_d = 16'd0;
            if (i_loss_interrupt) begin
               flush_cnt_d = '0;
               state_d     = S_FLUSH;
            end else begin
               rx_start_d = 1'b1;
               rx_addr_d  = base_q + ADDR_WIDTH'(wr_idx_q) * stride_q;
               state_d    = S_RUN;
            end
         end
         S_RUN: begin
            if (i_rx_interrupt && !complete) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
            end
            if (i_loss_interrupt || (!complete && !i_enable)) begin
               flush_cnt_d = '0;
               state_d     = S_FLUSH;
            end else if (complete) begin
               state_d = (fill_d == FILL_FULL) ? S_WAIT_BUF : S_START;
            end
         end
         S_WAIT_BUF: begin
            if (i_rx_interrupt) begin
               overflow_d = 1'b1;
            end
            if (i_loss_interrupt) begin
               flush_cnt_d = '0;
               state_d     = S_FLUSH;
            end else if (fill_q < FILL_FULL) begin
               state_d = S_START;
            end
         end
         S_FLUSH: begin
            flush_cnt_d = flush_cnt_q + FC_W'(1);
            if (i_fifo_empty || (flush_cnt_q == FLUSH_LAST)) begin
               srst_cnt_d  = 2'd0;
               frame_cnt_d = 16'd0;
               state_d     = S_SRST;
            end
         end
         S_SRST: begin
            srst_cnt_d = srst_cnt_q + 2'd1;
            if (srst_cnt_q == 2'd3) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Registered so that the soft reset is high exactly while in SRST.
      soft_rst_d = (state_d == S_SRST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         stride_q    <= '0;
         fpb_q       <= '0;
         frame_cnt_q <= '0;
         wr_idx_q    <= '0;
         fill_q      <= '0;
         flush_cnt_q <= '0;
         srst_cnt_q  <= '0;
         rx_start_q  <= 1'b0;
         rx_addr_q   <= '0;
         buf_done_q  <= 1'b0;
         done_idx_q  <= '0;
         soft_rst_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         stride_q    <= stride_d;
         fpb_q       <= fpb_d;
         frame_cnt_q <= frame_cnt_d;
         wr_idx_q    <= wr_idx_d;
         fill_q      <= fill_d;
         flush_cnt_q <= flush_cnt_d;
         srst_cnt_q  <= srst_cnt_d;
         rx_start_q  <= rx_start_d;
         rx_addr_q   <= rx_addr_d;
         buf_done_q  <= buf_done_d;
         done_idx_q  <= done_idx_d;
         soft_rst_q  <= soft_rst_d;
         overflow_q  <= overflow_d;
      end
   end

   assign o_rx_start     = rx_start_q;
   assign o_rx_base_addr = rx_addr_q;
   assign o_rx_fifo_rd   = (state_q == S_FLUSH) && !i_fifo_empty;
   assign o_soft_rst     = soft_rst_q;
   assign o_buf_done     = buf_done_q;
   assign o_buf_done_idx = done_idx_q;
   assign o_wr_idx       = wr_idx_q;
   assign o_fill_level   = fill_q;
   assign o_overflow     = overflow_q;
   assign o_state        = state_q;

endmodule

// File: tb/tb_tlk2711_rx_buf_ctrl.sv
// Bench for tlk2711_rx_buf_ctrl: config vector table plus directed sequences for
// full ring, simultaneous release, loss flush, flush timeout and async reset.
module tb_tlk2711_rx_buf_ctrl;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_FLUSH = 3'd4;
   localparam logic [2:0] ST_SRST  = 3'd5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_enable = 1'b0;
   logic [31:0] i_cfg_base_addr = '0;
   logic [31:0] i_cfg_buf_stride = '0;
   logic [15:0] i_cfg_frames_per_buf = '0;
   logic        i_buf_release = 1'b0;
   logic        i_rx_interrupt = 1'b0;
   logic        i_loss_interrupt = 1'b0;
   logic        i_fifo_empty = 1'b1;
   logic        o_rx_start;
   logic [31:0] o_rx_base_addr;
   logic        o_rx_fifo_rd;
   logic        o_soft_rst;
   logic        o_buf_done;
   logic [1:0]  o_buf_done_idx;
   logic [1:0]  o_wr_idx;
   logic [2:0]  o_fill_level;
   logic        o_overflow;
   logic [2:0]  o_state;

   tlk2711_rx_buf_ctrl dut (
      .clk                  (clk),
      .rst                  (rst),
      .i_enable             (i_enable),
      .i_cfg_base_addr      (i_cfg_base_addr),
      .i_cfg_buf_stride     (i_cfg_buf_stride),
      .i_cfg_frames_per_buf (i_cfg_frames_per_buf),
      .i_buf_release        (i_buf_release),
      .i_rx_interrupt       (i_rx_interrupt),
      .i_loss_interrupt     (i_loss_interrupt),
      .i_fifo_empty         (i_fifo_empty),
      .o_rx_start           (o_rx_start),
      .o_rx_base_addr       (o_rx_base_addr),
      .o_rx_fifo_rd         (o_rx_fifo_rd),
      .o_soft_rst           (o_soft_rst),
      .o_buf_done           (o_buf_done),
      .o_buf_done_idx       (o_buf_done_idx),
      .o_wr_idx             (o_wr_idx),
      .o_fill_level         (o_fill_level),
      .o_overflow           (o_overflow),
      .o_state              (o_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] base;
      logic [31:0] stride;
      logic [15:0] fpb;
      int          nslots;
      bit          rel_each;
      logic [2:0]  exp_state;
      logic [2:0]  exp_fill;
      logic [1:0]  exp_wr;
   } vec_t;

   vec_t        vecs[4];
   logic [33:0] exp_q[$];
   logic [1:0]  done_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          m_wr;
   int          m_fill;
   logic [31:0] cur_base;
   logic [31:0] cur_stride;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] slot_addr(input int idx);
      logic [31:0] off;
      off = cur_stride * 32'(idx);
      return cur_base + off;
   endfunction

   task automatic expect_start();
      exp_q.push_back({2'(m_wr), slot_addr(m_wr)});
   endtask

   // Starts and completions are checked as the DUT announces them.
   always @(negedge clk) begin
      if (!rst) begin
         if (o_rx_start) begin
            if (exp_q.size() == 0) check("unexpected_rx_start", {o_wr_idx, o_rx_base_addr}, 34'h0);
            else check("rx_start_idx_addr", {o_wr_idx, o_rx_base_addr}, exp_q.pop_front());
         end
         if (o_buf_done) begin
            if (done_q.size() == 0) check("unexpected_buf_done", {1'b1, o_buf_done_idx}, 3'h0);
            else check("buf_done_idx", o_buf_done_idx, done_q.pop_front());
         end
      end
   end

   task automatic wait_state(input logic [2:0] s, input string name);
      int n;
      n = 0;
      while (o_state != s && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (o_state != s) check(name, o_state, s);
   endtask

   task automatic send_frame(input bit last);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      wait_state(ST_RUN, "wait_run_timeout");
      i_rx_interrupt = 1'b1;
      if (last) begin
         done_q.push_back(2'(m_wr));
         m_wr = (m_wr + 1) % 4;
         m_fill++;
         if (m_fill < 4) expect_start();
      end
      @(negedge clk);
      i_rx_interrupt = 1'b0;
   endtask

   task automatic run_slot(input int fpb);
      for (int f = 0; f < fpb; f++) send_frame(f == fpb - 1);
   endtask

   task automatic do_reset();
      i_enable = 1'b0;
      i_buf_release = 1'b0;
      i_rx_interrupt = 1'b0;
      i_loss_interrupt = 1'b0;
      i_fifo_empty = 1'b1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      done_q.delete();
      m_wr = 0;
      m_fill = 0;
   endtask

   task automatic configure(input logic [31:0] b, input logic [31:0] s, input logic [15:0] f);
      cur_base = b;
      cur_stride = s;
      i_cfg_base_addr = b;
      i_cfg_buf_stride = s;
      i_cfg_frames_per_buf = f;
   endtask

   initial begin
      int rd_cnt;
      int srst_cnt;
      int fl;
      int starts;
      int non_idle;

      vecs[0] = '{32'h1000_0000, 32'h0010_0000, 16'd3, 2, 1'b0, ST_RUN,  3'd2, 2'd2};
      vecs[1] = '{32'hFFFF_FF00, 32'h0000_0080, 16'd1, 3, 1'b1, ST_RUN,  3'd0, 2'd3};
      vecs[2] = '{32'h0000_2000, 32'h0000_0400, 16'd2, 4, 1'b0, ST_WAIT, 3'd4, 2'd0};
      vecs[3] = '{32'h8000_0000, 32'h0000_1000, 16'd2, 6, 1'b1, ST_RUN,  3'd0, 2'd2};

      do_reset();
      check("reset_state", o_state, ST_IDLE);
      check("reset_outputs", {o_rx_start, o_rx_fifo_rd, o_soft_rst, o_buf_done, o_overflow}, 5'd0);
      check("reset_addr", o_rx_base_addr, 32'd0);
      check("reset_idx_fill", {o_wr_idx, o_fill_level, o_buf_done_idx}, 7'd0);

      for (int v = 0; v < 4; v++) begin
         do_reset();
         configure(vecs[v].base, vecs[v].stride, vecs[v].fpb);
         @(negedge clk);
         i_enable = 1'b1;
         expect_start();
         for (int s = 0; s < vecs[v].nslots; s++) begin
            run_slot(int'(vecs[v].fpb));
            if (vecs[v].rel_each) begin
               @(negedge clk);
               i_buf_release = 1'b1;
               m_fill--;
               @(negedge clk);
               i_buf_release = 1'b0;
            end
         end
         repeat (4) @(negedge clk);
         check("vec_state", o_state, vecs[v].exp_state);
         check("vec_fill", o_fill_level, vecs[v].exp_fill);
         check("vec_wr_idx", o_wr_idx, vecs[v].exp_wr);
         check("vec_start_q_empty", exp_q.size(), 0);
         check("vec_done_q_empty", done_q.size(), 0);
      end

      // Full ring, overflow, release restarts at wrapped slot 0.
      do_reset();
      configure(32'h1000_0000, 32'h0010_0000, 16'd3);
      @(negedge clk);
      i_enable = 1'b1;
      expect_start();
      for (int s = 0; s < 4; s++) run_slot(3);
      repeat (2) @(negedge clk);
      check("full_state", o_state, ST_WAIT);
      check("full_fill", o_fill_level, 3'd4);
      check("no_overflow_yet", o_overflow, 1'b0);
      i_rx_interrupt = 1'b1;
      @(negedge clk);
      i_rx_interrupt = 1'b0;
      @(negedge clk);
      check("overflow_set", o_overflow, 1'b1);
      check("overflow_fill_kept", o_fill_level, 3'd4);
      m_fill--;
      exp_q.push_back({2'd0, 32'h1000_0000});
      i_buf_release = 1'b1;
      @(negedge clk);
      i_buf_release = 1'b0;
      wait_state(ST_RUN, "release_restart_timeout");
      @(negedge clk);
      check("release_fill", o_fill_level, 3'd3);

      // Completion and release together: fill holds at 3, FSM restarts.
      send_frame(1'b0);
      send_frame(1'b0);
      wait_state(ST_RUN, "wait_run_timeout");
      i_rx_interrupt = 1'b1;
      i_buf_release = 1'b1;
      done_q.push_back(2'd0);
      m_wr = 1;
      exp_q.push_back({2'd1, 32'h1010_0000});
      @(negedge clk);
      i_rx_interrupt = 1'b0;
      i_buf_release = 1'b0;
      check("simul_state_start", o_state, ST_START);
      check("simul_fill", o_fill_level, 3'd3);
      check("simul_done", o_buf_done, 1'b1);

      // Loss mid-slot: 10 drain strobes, 4 soft-reset cycles, same slot restarts.
      send_frame(1'b0);
      wait_state(ST_RUN, "wait_run_timeout");
      i_fifo_empty = 1'b0;
      exp_q.push_back({2'd1, 32'h1010_0000});
      i_loss_interrupt = 1'b1;
      @(negedge clk);
      i_loss_interrupt = 1'b0;
      check("loss_enters_flush", o_state, ST_FLUSH);
      rd_cnt = 0;
      srst_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (o_rx_fifo_rd) rd_cnt++;
         if (o_soft_rst) srst_cnt++;
         if (rd_cnt == 10) i_fifo_empty = 1'b1;
         @(negedge clk);
      end
      check("flush_rd_cycles", rd_cnt, 10);
      check("soft_rst_cycles", srst_cnt, 4);
      check("restart_wr_idx", o_wr_idx, 2'd1);
      run_slot(3);
      repeat (2) @(negedge clk);
      check("after_loss_full", o_state, ST_WAIT);

      // Loss with FIFO never emptying: forced soft reset after the timeout.
      exp_q.push_back({2'd2, 32'h1020_0000});
      i_fifo_empty = 1'b0;
      i_loss_interrupt = 1'b1;
      @(negedge clk);
      i_loss_interrupt = 1'b0;
      check("timeout_rd_high", o_rx_fifo_rd, 1'b1);
      fl = 0;
      while (o_state == ST_FLUSH && fl < 5000) begin
         fl++;
         @(negedge clk);
      end
      check("flush_timeout_cycles", fl, 4096);
      check("timeout_to_srst", o_state, ST_SRST);
      i_fifo_empty = 1'b1;
      wait_state(ST_RUN, "timeout_restart");
      check("overflow_sticky", o_overflow, 1'b1);

      // Enable dropped in RUN: flush, soft reset, park in IDLE.
      i_enable = 1'b0;
      @(negedge clk);
      check("disable_flush", o_state, ST_FLUSH);
      repeat (8) @(negedge clk);
      check("disable_idle", o_state, ST_IDLE);
      check("disable_srst_low", o_soft_rst, 1'b0);

      // Asynchronous reset in RUN clears everything without a clock edge.
      i_enable = 1'b1;
      exp_q.push_back({2'd2, 32'h1020_0000});
      wait_state(ST_RUN, "pre_rst_run");
      send_frame(1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_state", o_state, ST_IDLE);
      check("async_rst_flags", {o_rx_start, o_rx_fifo_rd, o_soft_rst, o_buf_done, o_overflow}, 5'd0);
      check("async_rst_idx_fill", {o_wr_idx, o_fill_level, o_buf_done_idx}, 7'd0);
      check("async_rst_addr", o_rx_base_addr, 32'd0);
      i_cfg_frames_per_buf = 16'd0;
      @(negedge clk);
      rst = 1'b0;
      m_wr = 0;
      m_fill = 0;

      // Zero frames per slot: enable must not start the scheduler.
      starts = 0;
      non_idle = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (o_rx_start) starts++;
         if (o_state != ST_IDLE) non_idle++;
      end
      check("fpb0_no_start", starts, 0);
      check("fpb0_stays_idle", non_idle, 0);
      check("final_start_q_empty", exp_q.size(), 0);
      check("final_done_q_empty", done_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tlk2711_rx_buf_ctrl.md
Name: tlk2711_rx_buf_ctrl

Overview:
Ring-buffer scheduler for the TLK2711 RX link. It places received frames into NUM_BUF DDR buffer slots, each holding a fixed number of frames. It drives the link's start/base-address inputs and tracks fill level against host releases. On link/sync loss it drains the link's RX FIFO and issues a soft reset. It sits between the host register block and tlk2711_rx_link.

Parameters:
ADDR_WIDTH, 32, DDR byte-address width
NUM_BUF, 4, number of buffer slots (power of 2, 2..16)
IDX_W, 2, log2(NUM_BUF)
FLUSH_TO, 4096, max FLUSH cycles before forced soft reset

Ports:
clk  in  1  single clock; all logic synchronous to it
rst  in  1  asynchronous reset, active-high
i_enable  in  1  level; run scheduler
i_cfg_base_addr  in  ADDR_WIDTH  DDR address of slot 0
i_cfg_buf_stride  in  ADDR_WIDTH  byte distance between slots
i_cfg_frames_per_buf  in  16  frames per slot; 0 = invalid
i_buf_release  in  1  pulse; host has consumed the oldest full slot
i_rx_interrupt  in  1  pulse; link finished writing one frame to DDR
i_loss_interrupt  in  1  pulse; link or sync loss
i_fifo_empty  in  1  link RX FIFO empty
o_rx_start  out  1  one-cycle pulse; link loads o_rx_base_addr
o_rx_base_addr  out  ADDR_WIDTH  slot start address
o_rx_fifo_rd  out  1  drain strobe to link FIFO
o_soft_rst  out  1  soft reset to link
o_buf_done  out  1  pulse; slot complete
o_buf_done_idx  out  IDX_W  index of the completed slot
o_wr_idx  out  IDX_W  slot currently being filled
o_fill_level  out  IDX_W+1  completed, unreleased slots
o_overflow  out  1  sticky; frame arrived while all slots were full
o_state  out  3  FSM state, for host status

Behaviour:
- Async reset clears all regs and outputs to 0. State = IDLE.
- Config regs are latched on the IDLE->START transition and held until the FSM returns to IDLE.
- States: IDLE=0, START=1, RUN=2, WAIT_BUF=3, FLUSH=4, SRST=5.
- IDLE: go to START when i_enable=1 and i_cfg_frames_per_buf!=0.
- START: register o_rx_base_addr = base + wr_idx*stride, computed at ADDR_WIDTH and truncated modulo 2^ADDR_WIDTH. Pulse o_rx_start in the same cycle. Clear frame_cnt. Go to RUN next cycle.
- RUN, on i_rx_interrupt:
  - If frame_cnt < fpb-1: frame_cnt++.
  - If frame_cnt == fpb-1: the slot completes.
    - Next cycle: o_buf_done=1 and o_buf_done_idx=wr_idx.
    - wr_idx increments, wrapping NUM_BUF-1 -> 0.
    - fill increments.
    - Go to WAIT_BUF if the new fill == NUM_BUF, else START.
- RUN, i_enable=0: go to FLUSH.
- WAIT_BUF: when fill < NUM_BUF, go to START.
  - i_rx_interrupt here sets o_overflow. The frame is not counted.
- fill update:
  - i_buf_release with fill>0 decrements fill.
  - i_buf_release at fill=0 is ignored.
  - Completion and release in the same cycle leave fill unchanged. The FSM then goes to START, not WAIT_BUF.
- i_loss_interrupt in START, RUN or WAIT_BUF goes to FLUSH and has priority.
  - A coincident i_rx_interrupt in RUN is still counted and may complete the slot. The FSM still goes to FLUSH.
- FLUSH:
  - o_rx_fifo_rd = ~i_fifo_empty, combinational.
  - A flush counter increments every cycle.
  - Go to SRST when i_fifo_empty=1 or counter == FLUSH_TO-1.
- SRST:
  - o_soft_rst=1 for exactly 4 cycles.
  - frame_cnt clears; the partial slot is discarded.
  - wr_idx and fill are kept.
  - Then go to IDLE; operation restarts at the same wr_idx if i_enable=1.
- i_loss_interrupt in FLUSH or SRST is ignored.
- o_overflow clears only on rst.
- o_state = current state; all other outputs are registered.

Test Plan:
1. base=0x1000_0000, stride=0x10_0000, fpb=3, NUM_BUF=4, enable; send 3 rx_interrupts.
   -> o_rx_start with addr 0x1000_0000; o_buf_done idx0; second start addr 0x1010_0000; fill=1.
2. Fill all 4 slots with no release.
   -> state=WAIT_BUF, fill=4. An extra interrupt sets o_overflow=1. One release -> START at addr 0x1000_0000 (wr_idx wrapped to 0).
3. fill=3, release in the same cycle as the completing interrupt.
   -> fill stays 3; FSM goes to START, not WAIT_BUF.
4. loss pulse mid-slot (frame_cnt=1), fifo_empty low for 10 cycles.
   -> o_rx_fifo_rd high for exactly 10 cycles; o_soft_rst high for 4 cycles; restart at the same slot address with frame_cnt=0.
5. loss pulse with fifo_empty stuck low.
   -> SRST entered after 4096 FLUSH cycles.
6. fpb=0 with enable -> stays IDLE, no o_rx_start. Assert rst mid-RUN -> all outputs 0 immediately (asynchronous).
